// File: rtl/mo_mul_lanes.sv
`default_nettype none
// ============================================================================
// Module   : mo_mul_lanes
// Purpose  : Multi-lane, fully pipelined radix-2 Montgomery multiplier
//            (MWR2MM) with valid/ready flow control. Each lane computes
//            res = a * b * 2^-WIDTH mod Q. A credit-checked output FIFO
//            absorbs downstream stalls, so the arithmetic pipeline never stalls.
//
// Ports    : clk        rising-edge clock
//            rst_n      synchronous reset, active-low
//            in_valid   input beat valid
//            in_ready   block can accept a beat this cycle
//            in_a       multiplicands, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//            in_b       multipliers,   lane k at [k*WIDTH +: WIDTH]
//            out_valid  out_res valid (head of output FIFO)
//            out_ready  downstream accepts
//            out_res    results, same lane packing as in_a
//            busy       any beat in flight or buffered
//
// Build option:
//            MO_MUL_LANES_FULL_REDUCE_EN  adds a final res>=Q ? res-Q : res
//                                         stage (output strictly 0..Q-1,
//                                         latency +1).
//
// Latency  : LAT = ceil(WIDTH/ITER_PER_FF) + 2 (+1 with full reduce) cycles
//            from accept to FIFO write; out_valid rises one cycle later.
//
// Revision : 1.0  initial release
// ============================================================================
module mo_mul_lanes #(
  parameter int LANES       = 2,
  parameter int DATA_WIDTH  = 12,
  parameter int WIDTH       = DATA_WIDTH,
  parameter int ITER_PER_FF = 3,
  parameter int OBUF_DEPTH  = 8,
  parameter int Q           = 3329
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0]      in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_res,
  output logic                        busy
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  // Accumulator keeps the invariant S < 2Q; the pre-shift sum S + a + Q stays
  // below 4Q, hence two guard bits over DATA_WIDTH.
  localparam int SW   = DATA_WIDTH + 2;
  localparam int NSTG = (WIDTH + ITER_PER_FF - 1) / ITER_PER_FF;
`ifdef MO_MUL_LANES_FULL_REDUCE_EN
  localparam int FR_STAGES = 1;
`else
  localparam int FR_STAGES = 0;
`endif
  localparam int LAT = NSTG + 2 + FR_STAGES;
  localparam int PW  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW  = $clog2(OBUF_DEPTH + 1);

  localparam logic [SW-1:0] Q_S      = SW'(Q);
  localparam logic [PW-1:0] PTR_LAST = PW'(OBUF_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(OBUF_DEPTH);

  typedef logic [LANES-1:0][SW-1:0]         acc_t;
  typedef logic [LANES-1:0][DATA_WIDTH-1:0] opa_t;
  typedef logic [LANES-1:0][WIDTH-1:0]      opb_t;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // One MWR2MM iteration: S += b_i ? a : 0; if S odd, S += Q; S >>= 1.
  function automatic logic [SW-1:0] mwr2mm_step(input logic [SW-1:0]         s,
                                                input logic [DATA_WIDTH-1:0] a,
                                                input logic                  bit_i);
    logic [SW-1:0] t;
    t = s + (bit_i ? {2'b00, a} : '0);
    if (t[0]) begin
      t = t + Q_S;
    end
    return {1'b0, t[SW-1:1]};
  endfunction

  // Bit select through a shift so unrolled out-of-range indices read as 0.
  function automatic logic bit_at(input logic [WIDTH-1:0] v, input int idx);
    logic [WIDTH-1:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake / credit
  // --------------------------------------------------------------------------
  logic [LAT-1:0] vld_q, vld_d;
  logic [CW-1:0]  cnt_q, cnt_d;   // entries held in the output FIFO
  logic [CW-1:0]  occ_q, occ_d;   // FIFO entries plus beats in the pipeline
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           accept;
  logic           deliver;
  logic           wr_en;

  // occ_q tracks fifo_count + inflight as one counter: a pipeline-to-FIFO
  // move leaves it unchanged, so it only moves on accept and deliver.
  assign in_ready  = rst_n && (occ_q < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign out_valid = (cnt_q != '0);
  assign deliver   = out_valid && out_ready;
  assign busy      = (occ_q != '0);
  assign wr_en     = vld_q[LAT-1];

  // --------------------------------------------------------------------------
  // Iteration stages: ITER_PER_FF unrolled iterations per register
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NSTG; g++) begin : g_stg
    acc_t s_in;
    acc_t s_d;
    acc_t s_q;
    opa_t a_in;
    opb_t b_in;

    if (g == 0) begin : g_src
      assign s_in = '0;
      assign a_in = in_a;
      assign b_in = in_b;
    end else begin : g_src
      assign s_in = g_stg[g-1].s_q;
      assign a_in = g_stg[g-1].g_fwd.a_q;
      assign b_in = g_stg[g-1].g_fwd.b_q;
    end

    always_comb begin
      s_d = s_in;
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < ITER_PER_FF; k++) begin
          // The last stage may carry fewer than ITER_PER_FF iterations.
          if (g * ITER_PER_FF + k < WIDTH) begin
            s_d[l] = mwr2mm_step(s_d[l], a_in[l], bit_at(b_in[l], g * ITER_PER_FF + k));
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      s_q <= s_d;
    end

    // Operands only travel as far as the last stage that still consumes them.
    if (g < NSTG - 1) begin : g_fwd
      opa_t a_q;
      opb_t b_q;
      always_ff @(posedge clk) begin
        a_q <= a_in;
        b_q <= b_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reduce stage: final accumulator minus Q (two's complement, sign = MSB).
  // S is in [0,2Q), so the difference is in [-Q,Q).
  // --------------------------------------------------------------------------
  acc_t red_q;
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      red_q[l] <= g_stg[NSTG-1].s_q[l] - Q_S;
    end
  end

  // --------------------------------------------------------------------------
  // Correction stage: add Q back when negative.
  // --------------------------------------------------------------------------
  opa_t cor_q;
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      cor_q[l] <= red_q[l][SW-1] ? DATA_WIDTH'(red_q[l] + Q_S)
                                 : red_q[l][DATA_WIDTH-1:0];
    end
  end

  opa_t res_w;

`ifdef MO_MUL_LANES_FULL_REDUCE_EN
  localparam logic [DATA_WIDTH-1:0] Q_D = DATA_WIDTH'(Q);
  opa_t fr_q;
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      fr_q[l] <= (cor_q[l] >= Q_D) ? cor_q[l] - Q_D : cor_q[l];
    end
  end
  assign res_w = fr_q;
`else
  assign res_w = cor_q;
`endif

  // --------------------------------------------------------------------------
  // Control state: valid shift register, FIFO pointers and counters
  // --------------------------------------------------------------------------
  always_comb begin
    vld_d    = {vld_q[LAT-2:0], accept};
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (deliver) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    // Write and read in the same cycle leave the count unchanged, even full.
    cnt_d = cnt_q + CW'(wr_en) - CW'(deliver);
    occ_d = occ_q + CW'(accept) - CW'(deliver);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO storage (show-ahead: head entry drives out_res directly)
  // --------------------------------------------------------------------------
  opa_t mem_q [OBUF_DEPTH];
  opa_t head_w;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= res_w;
    end
  end

  // Storage is never reset, so an empty FIFO forces the output to zero.
  assign head_w  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_res = head_w;

endmodule
`default_nettype wire

// File: tb/tb_mo_mul_lanes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mo_mul_lanes
// Purpose  : Self-checking bench for mo_mul_lanes (Q=3329, 12-bit, 2 lanes,
//            3 iterations per register, 8-entry output buffer). Table of
//            hand-computed vectors plus directed streaming, backpressure,
//            simultaneous full read/write and mid-stream reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_mo_mul_lanes;

  localparam int LANES = 2;
  localparam int DW    = 12;
  localparam int Q     = 3329;
  localparam int IPF   = 3;
  localparam int DEPTH = 8;
  localparam int RINV  = 2704;   // 4096^-1 mod 3329
`ifdef MO_MUL_LANES_FULL_REDUCE_EN
  localparam bit FR = 1'b1;
`else
  localparam bit FR = 1'b0;
`endif
  localparam int LAT = (DW + IPF - 1) / IPF + 2 + (FR ? 1 : 0);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] in_a = '0;
  logic [23:0] in_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_res;
  logic        busy;

  always #5 clk = ~clk;

  mo_mul_lanes #(
    .LANES(LANES), .DATA_WIDTH(DW), .WIDTH(DW), .ITER_PER_FF(IPF),
    .OBUF_DEPTH(DEPTH), .Q(Q)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q [$];

  typedef struct {
    logic [11:0] a0, b0, a1, b1, e0, e1;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int model(input int a, input int b);
    longint p;
    p = (longint'(a) * longint'(b)) % Q;
    p = (p * RINV) % Q;
    return int'(p);
  endfunction

  // Without full reduction a zero result may legally appear as Q.
  function automatic bit lane_ok(input logic [11:0] r, input logic [11:0] e);
    return (r == e) || (!FR && e == 12'd0 && r == 12'(Q));
  endfunction

  task automatic gen_beat(output logic [23:0] a, output logic [23:0] b, output logic [23:0] e);
    int a0, b0, a1, b1;
    a0 = int'($urandom_range(Q - 1, 0));
    b0 = int'($urandom_range(Q - 1, 0));
    a1 = int'($urandom_range(Q - 1, 0));
    b1 = int'($urandom_range(Q - 1, 0));
    a = {12'(a1), 12'(a0)};
    b = {12'(b1), 12'(b0)};
    e = {12'(model(a1, b1)), 12'(model(a0, b0))};
  endtask

  // One clock cycle: drive at the falling edge, then evaluate the handshakes
  // that the next rising edge will perform. Deliveries are scored in order.
  task automatic cycle(input logic iv, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] e, input logic ordy,
                       output logic acc, output logic dlv);
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    acc = in_valid & in_ready;
    dlv = out_valid & out_ready;
    if (dlv) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %0d/%0d, expected no beat", out_res[11:0], out_res[23:12]);
      end else begin
        logic [23:0] x;
        x = exp_q.pop_front();
        if (!(lane_ok(out_res[11:0], x[11:0]) && lane_ok(out_res[23:12], x[23:12]))) begin
          n_err++;
          $display("FAIL result: got %0d/%0d, expected %0d/%0d",
                   out_res[11:0], out_res[23:12], x[11:0], x[23:12]);
        end
      end
    end
    if (acc) exp_q.push_back(e);
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    logic acc, dlv;
    int   n;
    cycle(1'b1, {v.a1, v.a0}, {v.b1, v.b0}, {v.e1, v.e0}, 1'b1, acc, dlv);
    check({tag, "_accept"}, int'(acc), 1);
    n = 0;
    dlv = 1'b0;
    while (!dlv && n < 40) begin
      cycle(1'b0, '0, '0, '0, 1'b1, acc, dlv);
      n++;
    end
    check({tag, "_latency"}, n, LAT + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, dlv;
    logic [23:0] ca, cb, ce;
    int          n, beats, deliv, stalls, first, last, cyc;

    tbl[0] = '{12'd5,    12'd767,  12'd3328, 12'd767,  12'd5,    12'd3328};
    tbl[1] = '{12'd0,    12'd1234, 12'd1,    12'd0,    12'd0,    12'd0};
    tbl[2] = '{12'd1,    12'd1,    12'd3328, 12'd1,    12'd2704, 12'd625};
    tbl[3] = '{12'd2,    12'd1,    12'd1,    12'd2,    12'd2079, 12'd2079};
    tbl[4] = '{12'd767,  12'd767,  12'd1,    12'd767,  12'd767,  12'd1};
    tbl[5] = '{12'd1000, 12'd767,  12'd3328, 12'd3328, 12'd1000, 12'd2704};
    tbl[6] = '{12'd2,    12'd2,    12'd3328, 12'd2,    12'd829,  12'd1250};
    tbl[7] = '{12'd3328, 12'd3328, 12'd0,    12'd0,    12'd2704, 12'd0};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    #1;
    check("ready_in_reset", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", int'(in_ready), 1);
    check("valid_after_reset", int'(out_valid), 0);
    check("busy_after_reset", int'(busy), 0);
    check("res_after_reset", int'(out_res), 0);

    // ---------------- table vectors, one at a time ----------------
    for (int i = 0; i < 8; i++) begin
      run_vector(tbl[i], $sformatf("vec%0d", i));
    end
    cycle(1'b0, '0, '0, '0, 1'b1, acc, dlv);
    check("idle_busy", int'(busy), 0);

    // ---------------- streaming ----------------
    beats = 0; deliv = 0; stalls = 0; first = -1; last = -1; cyc = 0;
    gen_beat(ca, cb, ce);
    while (beats < 1000) begin
      cycle(1'b1, ca, cb, ce, 1'b1, acc, dlv);
      if (acc) begin
        beats++;
        gen_beat(ca, cb, ce);
      end else begin
        stalls++;
      end
      if (dlv) begin
        deliv++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      cyc++;
    end
    for (int i = 0; i < 60 && deliv < 1000; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, acc, dlv);
      if (dlv) begin
        deliv++;
        last = cyc;
      end
      cyc++;
    end
    check("stream_count", deliv, 1000);
`ifndef MO_MUL_LANES_FULL_REDUCE_EN
    check("stream_stalls", stalls, 0);
    check("stream_span", last - first + 1, 1000);
`endif

    // ---------------- backpressure ----------------
    cycle(1'b0, '0, '0, '0, 1'b1, acc, dlv);
    n = 0;
    gen_beat(ca, cb, ce);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, ca, cb, ce, 1'b0, acc, dlv);
      if (acc) begin
        n++;
        gen_beat(ca, cb, ce);
      end
    end
    check("bp_accepts", n, DEPTH);
    check("bp_ready", int'(in_ready), 0);
    check("bp_valid", int'(out_valid), 1);

    // ---------------- simultaneous deliver with full buffer ----------------
    cycle(1'b1, ca, cb, ce, 1'b1, acc, dlv);
    check("full_accept", int'(acc), 0);
    check("full_deliver", int'(dlv), 1);
    if (acc) gen_beat(ca, cb, ce);
    cycle(1'b1, ca, cb, ce, 1'b1, acc, dlv);
    check("refill_accept", int'(acc), 1);
    check("refill_deliver", int'(dlv), 1);
    if (acc) gen_beat(ca, cb, ce);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, ca, cb, ce, 1'b1, acc, dlv);
      if (acc) begin
        n++;
        gen_beat(ca, cb, ce);
      end
    end
`ifndef MO_MUL_LANES_FULL_REDUCE_EN
    check("post_bp_throughput", n, 30);
`endif
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, acc, dlv);
      if (exp_q.size() == 0 && !busy) break;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", int'(busy), 0);

    // ---------------- reset mid-stream ----------------
    n = 0;
    for (int i = 0; i < 5; i++) begin
      gen_beat(ca, cb, ce);
      cycle(1'b1, ca, cb, ce, 1'b1, acc, dlv);
      if (acc) n++;
    end
    check("pre_reset_accepts", n, 5);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_ready_low", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(in_ready), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, acc, dlv);
      if (dlv) n++;
    end
    check("stale_outputs", n, 0);
    run_vector(tbl[6], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
